// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register of the 5-stage MIPS core.
// Owns the fetch PC, drives the instruction memory address, latches the
// fetched word for decode and resolves jump/branch targets from the
// instruction currently held in ID. The branch delay slot is architectural:
// a redirect never squashes the instruction already in IF.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jump_r,
    input  logic [31:0] jr_target,
    output logic [31:0] F_pc,
    output logic [31:0] D_inst,
    output logic [31:0] D_pc,
    output logic [31:0] D_pc8,
    output logic        D_valid,
    output logic        D_adel,
    output logic [31:0] fetch_count
);

    localparam int unsigned XLEN     = 32;
    localparam int unsigned IMM_W    = 16;
    localparam int unsigned JIDX_W   = 26;
    localparam logic [XLEN-1:0] PC_STEP  = 32'd4;
    localparam logic [XLEN-1:0] LINK_OFS = 32'd8;
    localparam logic [XLEN-1:0] CNT_ONE  = 32'd1;

    // IF/ID pipeline payload
    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc8;
        logic            valid;
        logic            adel;
    } ifid_t;

    logic [XLEN-1:0] f_pc_q, f_pc_d;
    ifid_t           ifid_q, ifid_d;
    logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;

    logic [XLEN-1:0] f_pc_plus4;
    logic [XLEN-1:0] f_pc_plus8;
    logic [XLEN-1:0] d_pc_plus4;
    logic [XLEN-1:0] br_offset;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] j_target;
    logic            f_misaligned;
    logic            ifid_load;

    // Sequential-PC arithmetic and ID-stage target computation
    always_comb begin
        f_pc_plus4   = f_pc_q + PC_STEP;
        f_pc_plus8   = f_pc_q + LINK_OFS;
        d_pc_plus4   = ifid_q.pc + PC_STEP;
        br_offset    = {{(XLEN-IMM_W-2){ifid_q.inst[IMM_W-1]}}, ifid_q.inst[IMM_W-1:0], 2'b00};
        br_target    = d_pc_plus4 + br_offset;
        j_target     = {d_pc_plus4[XLEN-1:XLEN-4], ifid_q.inst[JIDX_W-1:0], 2'b00};
        f_misaligned = (f_pc_q[1:0] != 2'b00);
    end

    // Next-PC select; redirects only count when ID holds a real instruction
    always_comb begin
        f_pc_d = f_pc_plus4;
        if (stall) begin
            f_pc_d = f_pc_q;
        end else if (ifid_q.valid && jump_r) begin
            f_pc_d = jr_target;
        end else if (ifid_q.valid && jump) begin
            f_pc_d = j_target;
        end else if (ifid_q.valid && branch_taken) begin
            f_pc_d = br_target;
        end
    end

    // IF/ID update: flush beats stall; misaligned fetches become a flagged NOP
    always_comb begin
        ifid_d      = ifid_q;
        fetch_cnt_d = fetch_cnt_q;
        ifid_load   = 1'b0;
        if (flush) begin
            ifid_d.inst  = NOP_WORD;
            ifid_d.pc    = f_pc_q;
            ifid_d.pc8   = f_pc_plus8;
            ifid_d.valid = 1'b0;
            ifid_d.adel  = 1'b0;
        end else if (!stall) begin
            ifid_load    = 1'b1;
            ifid_d.inst  = f_misaligned ? NOP_WORD : im_rdata;
            ifid_d.pc    = f_pc_q;
            ifid_d.pc8   = f_pc_plus8;
            ifid_d.valid = 1'b1;
            ifid_d.adel  = f_misaligned;
        end
        if (ifid_load) begin
            fetch_cnt_d = fetch_cnt_q + CNT_ONE;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_pc_q       <= RESET_PC;
            ifid_q.inst  <= NOP_WORD;
            ifid_q.pc    <= '0;
            ifid_q.pc8   <= LINK_OFS;
            ifid_q.valid <= 1'b0;
            ifid_q.adel  <= 1'b0;
            fetch_cnt_q  <= '0;
        end else begin
            f_pc_q      <= f_pc_d;
            ifid_q      <= ifid_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign im_addr     = f_pc_q;
    assign F_pc        = f_pc_q;
    assign D_inst      = ifid_q.inst;
    assign D_pc        = ifid_q.pc;
    assign D_pc8       = ifid_q.pc8;
    assign D_valid     = ifid_q.valid;
    assign D_adel      = ifid_q.adel;
    assign fetch_count = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a behavioural model predicts the
// architectural state after every edge, a monitor compares it mid-cycle.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        branch_taken = 1'b0;
    logic        jump = 1'b0;
    logic        jump_r = 1'b0;
    logic [31:0] jr_target = 32'h0;
    logic [31:0] F_pc, D_inst, D_pc, D_pc8, fetch_count;
    logic        D_valid, D_adel;

    fetch_stage dut (
        .clk(clk), .reset_n(reset_n), .im_addr(im_addr), .im_rdata(im_rdata),
        .stall(stall), .flush(flush), .branch_taken(branch_taken), .jump(jump),
        .jump_r(jump_r), .jr_target(jr_target), .F_pc(F_pc), .D_inst(D_inst),
        .D_pc(D_pc), .D_pc8(D_pc8), .D_valid(D_valid), .D_adel(D_adel),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Instruction memory: per-address overrides, else a constant or hashed word
    logic [31:0] ovr [bit [31:0]];
    bit          use_hash = 1'b0;
    int          mem_rev = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (ovr.exists(a)) return ovr[a];
        if (use_hash) return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
        return 32'h2408_0001;
    endfunction

    always @(im_addr, use_hash, mem_rev) im_rdata = mem_word(im_addr);

    // Reference state
    logic [31:0] m_pc, m_dinst, m_dpc, m_dpc8, m_cnt;
    logic        m_dvalid, m_dadel;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] dpc;
        logic [31:0] dpc8;
        logic [31:0] cnt;
        logic        valid;
        logic        adel;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0000_3000; m_dinst = NOP; m_dpc = 32'h0; m_dpc8 = 32'h8;
        m_dvalid = 1'b0; m_dadel = 1'b0; m_cnt = 32'h0;
    endtask

    // One clock edge of architectural behaviour
    task automatic model_step();
        logic [31:0] nxt;
        logic [31:0] sext;
        sext = {{16{m_dinst[15]}}, m_dinst[15:0]};
        if (stall)                         nxt = m_pc;
        else if (m_dvalid && jump_r)       nxt = jr_target;
        else if (m_dvalid && jump)         nxt = ((m_dpc + 32'd4) & 32'hF000_0000) | ((m_dinst & 32'h03FF_FFFF) << 2);
        else if (m_dvalid && branch_taken) nxt = m_dpc + 32'd4 + sext * 32'd4;
        else                               nxt = m_pc + 32'd4;
        if (flush) begin
            m_dinst = NOP; m_dvalid = 1'b0; m_dadel = 1'b0;
            m_dpc = m_pc; m_dpc8 = m_pc + 32'd8;
        end else if (!stall) begin
            m_dadel  = (m_pc % 4) != 0;
            m_dinst  = m_dadel ? NOP : mem_word(m_pc);
            m_dpc    = m_pc; m_dpc8 = m_pc + 32'd8;
            m_dvalid = 1'b1;
            m_cnt    = m_cnt + 32'd1;
        end
        m_pc = nxt;
    endtask

    task automatic push_exp();
        exp_t e;
        e.pc = m_pc; e.inst = m_dinst; e.dpc = m_dpc; e.dpc8 = m_dpc8;
        e.cnt = m_cnt; e.valid = m_dvalid; e.adel = m_dadel;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk); #1;
        model_step();
        push_exp();
    endtask

    // Reset asserted mid-cycle after an edge, released before the next one
    task automatic pulse_reset();
        @(posedge clk); #2;
        reset_n = 1'b0;
        model_reset();
        push_exp();
        @(negedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic set_in(input logic s, input logic f, input logic b, input logic j,
                          input logic jr, input logic [31:0] jrt);
        stall = s; flush = f; branch_taken = b; jump = j; jump_r = jr; jr_target = jrt;
    endtask

    // Monitor: compare DUT state with the oldest prediction, away from the edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("im_addr", im_addr, e.pc);
                chk("F_pc", F_pc, e.pc);
                chk("D_inst", D_inst, e.inst);
                chk("D_pc", D_pc, e.dpc);
                chk("D_pc8", D_pc8, e.dpc8);
                chk("D_valid", 32'(D_valid), 32'(e.valid));
                chk("D_adel", 32'(D_adel), 32'(e.adel));
                chk("fetch_count", fetch_count, e.cnt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Free-running fetch with a constant instruction word
        pulse_reset();
        set_in(0, 0, 0, 0, 0, 32'h0);
        tick();
        chk("plan_dpc8_first", m_dpc8, 32'h0000_3008);
        tick();
        chk("plan_dpc_second", m_dpc, 32'h0000_3004);
        chk("plan_count_two", m_cnt, 32'd2);
        tick();
        chk("plan_fpc_third", m_pc, 32'h0000_300C);

        // BEQ back by one word; the slot at 0x3008 still enters ID
        ovr.delete(); ovr[32'h3004] = 32'h1000_FFFF; mem_rev++;
        pulse_reset();
        tick(); tick();
        set_in(0, 0, 1, 0, 0, 32'h0);
        tick();
        chk("plan_beq_fpc", m_pc, 32'h0000_3004);
        chk("plan_beq_slot", m_dpc, 32'h0000_3008);
        set_in(0, 0, 0, 0, 0, 32'h0);
        tick();

        // J to 0x3040, then JR to a misaligned address
        ovr.delete(); ovr[32'h3000] = 32'h0800_0C10; mem_rev++;
        pulse_reset();
        tick();
        set_in(0, 0, 0, 1, 0, 32'h0);
        tick();
        chk("plan_j_fpc", m_pc, 32'h0000_3040);
        set_in(0, 0, 0, 0, 1, 32'h0000_3002);
        tick();
        chk("plan_jr_fpc", m_pc, 32'h0000_3002);
        set_in(0, 0, 0, 0, 0, 32'h0);
        tick();
        chk("plan_jr_adel", 32'(m_dadel), 32'd1);
        tick();

        // Three stalled cycles with a taken BNE held in ID
        ovr.delete(); ovr[32'h3004] = 32'h1400_0010; mem_rev++;
        pulse_reset();
        tick(); tick();
        set_in(1, 0, 1, 0, 0, 32'h0);
        tick(); tick(); tick();
        set_in(0, 0, 1, 0, 0, 32'h0);
        tick();
        chk("plan_bne_release", m_pc, 32'h0000_3048);
        set_in(0, 0, 0, 0, 0, 32'h0);
        tick();

        // Flush during stall, then a mid-cycle reset pulse
        set_in(1, 1, 0, 0, 0, 32'h0);
        tick();
        chk("plan_stallflush_valid", 32'(m_dvalid), 32'd0);
        set_in(0, 0, 0, 0, 0, 32'h0);
        tick();
        pulse_reset();

        // Wrap from the top of the address space
        tick();
        set_in(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        tick();
        set_in(0, 0, 0, 0, 0, 32'h0);
        tick();
        chk("plan_wrap_fpc", m_pc, 32'h0000_0000);
        chk("plan_wrap_dpc8", m_dpc8, 32'h0000_0004);
        tick();

        // Randomised traffic
        ovr.delete(); use_hash = 1'b1; mem_rev++;
        pulse_reset();
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] t;
            t = $urandom();
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            set_in($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 12,
                   $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10,
                   $urandom_range(0, 99) < 8, t);
            if ($urandom_range(0, 199) == 0) pulse_reset();
            else tick();
        end

        @(negedge clk); #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
